// File: rtl/apb_master_pkg.sv
// Shared types and address helpers for the APB requester and the benches that drive it.
package apb_master_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_mst_state_e;

    localparam int SLAVE_ID_MSB = 15;
    localparam int SLAVE_ID_LSB = 12;

    // Build a 16-bit APB address from a slave ID and a byte offset inside that slave.
    function automatic logic [15:0] slave_addr(input logic [3:0] id, input logic [11:0] offset);
        return {id, offset};
    endfunction

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: valid/ready command in, SETUP+ACCESS transfer out,
// one-cycle response pulse back, with a watchdog that aborts transfers stuck on PREADY.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// APB_IDLE   | cmd_ready=1, waiting for cmd_valid; APB address/data held
// APB_SETUP  | PSELx=1, PENABLE=0 for exactly one cycle
// APB_ACCESS | PSELx=PENABLE=1 until PREADY or watchdog expiry
module apb_master
    import apb_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    if ((TIMEOUT_CYCLES >> CNT_WIDTH) != 0) begin : g_cnt_width_check
        $error("apb_master: CNT_WIDTH too small to hold TIMEOUT_CYCLES");
    end

    localparam bit                 WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    apb_mst_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0]  watchdog_q, watchdog_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  wd_expire;

    // PREADY is checked before this, so a ready slave on the expiry cycle still succeeds.
    assign wd_expire = WD_EN && (watchdog_q == WD_LAST);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= APB_IDLE;
            watchdog_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            watchdog_q  <= watchdog_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_IDLE:   if (cmd_valid) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: if (PREADY || wd_expire) state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_comb begin
        watchdog_d  = watchdog_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            APB_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            APB_SETUP: begin
                penable_d  = 1'b1;
                watchdog_d = '0;
            end
            APB_ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (wd_expire) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (watchdog_q != '1) begin
                    watchdog_d = watchdog_q + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == APB_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: memory-backed slave with programmable wait states, a transfer-level
// reference model compared every cycle, plus directed checks of latency and corner cases.
module tb_apb_master;
    import apb_master_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 16;
    localparam int CW = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, rsp_err, PSELx, PENABLE, PWRITE;
    logic [DW-1:0] rsp_rdata, PWDATA;
    logic [AW-1:0] PADDR;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;

    logic          cmd_valid0 = 1'b0;
    logic          cmd_ready0, rsp_valid0, rsp_err0, psel0, penable0, pwrite0;
    logic [DW-1:0] rsp_rdata0, pwdata0;
    logic [AW-1:0] paddr0;

    always #5 PCLK = ~PCLK;

    apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(0), .CNT_WIDTH(CW)) dut_nowd (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(1'b1),
        .cmd_addr(16'h1010), .cmd_wdata(32'h0000_1234),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .PSELx(psel0), .PENABLE(penable0), .PWRITE(pwrite0), .PADDR(paddr0), .PWDATA(pwdata0),
        .PREADY(1'b0), .PRDATA(32'h0)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: PREADY low for slave_wait ACCESS cycles, then high; stall keeps it low forever.
    int            slave_wait = 0;
    bit            stall = 1'b0;
    int            acc_cnt = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    always @(posedge PCLK) begin
        #2;
        if (PSELx && PENABLE) begin
            if (!stall && acc_cnt >= slave_wait) begin
                PREADY = 1'b1;
                PRDATA = mem.exists(PADDR) ? mem[PADDR] : 32'h0;
                if (PWRITE) mem[PADDR] = PWDATA;
            end else begin
                PREADY = 1'b0;
                PRDATA = 32'hA5A5_A5A5;
            end
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'hA5A5_A5A5;
            acc_cnt = 0;
        end
    end

    // Transfer-level model: age = cycles since the command was taken (0 = setup, n = nth access).
    bit            cmp_en = 1'b0;
    bit            m_busy = 1'b0;
    int            m_age = 0;
    logic          m_psel = 1'b0, m_pen = 1'b0, m_pwrite = 1'b0, m_rv = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pwdata = '0, m_rdata = '0;
    int            accept_edge = 0, lat = 0, pen_cnt = 0, rsp_cnt = 0;
    int            acc_edges[$];

    always @(negedge PCLK) begin
        if (cmp_en) begin
            check("cmd_ready", cmd_ready, !m_busy);
            check("PSELx", PSELx, m_psel);
            check("PENABLE", PENABLE, m_pen);
            check("PWRITE", PWRITE, m_pwrite);
            check("PADDR", PADDR, m_paddr);
            check("PWDATA", PWDATA, m_pwdata);
            check("rsp_valid", rsp_valid, m_rv);
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", rsp_err, m_err);
        end
        if (PENABLE) pen_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            lat = cyc - accept_edge;
        end
        m_rv = 1'b0;
        if (!PRESETn) begin
            m_busy = 1'b0; m_psel = 1'b0; m_pen = 1'b0; m_pwrite = 1'b0;
            m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1'b1; m_age = 0; m_psel = 1'b1; m_pen = 1'b0;
                m_pwrite = cmd_write; m_paddr = cmd_addr; m_pwdata = cmd_wdata;
                accept_edge = cyc + 1;
                pen_cnt = 0;
                acc_edges.push_back(cyc + 1);
            end
        end else if (m_age == 0) begin
            m_age = 1;
            m_pen = 1'b1;
        end else if (PREADY || (TO != 0 && m_age == TO)) begin
            m_busy = 1'b0; m_psel = 1'b0; m_pen = 1'b0; m_rv = 1'b1;
            m_err   = !PREADY;
            m_rdata = (PREADY && !m_pwrite) ? PRDATA : '0;
        end else begin
            m_age++;
        end
    end

    task automatic do_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output bit er);
        bit ok;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        ok = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                ok = 1'b1; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        #1;
        check("rsp_arrived", ok, 1'b1);
    endtask

    logic [DW-1:0] rd;
    bit            er;
    int            r0, bad;
    bit            got;
    logic [DW-1:0] vals [4] = '{32'hA0A0_A0A0, 32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_0F0F};

    initial begin
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_PSELx", PSELx, 0);
        check("rst_PENABLE", PENABLE, 0);
        check("rst_PADDR", PADDR, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        cmp_en  = 1'b1;
        PRESETn = 1'b1;

        do_cmd(1'b1, slave_addr(4'h1, 12'h004), 32'hDEAD_BEEF, rd, er);
        check("wr_err", er, 0);
        check("wr_rdata", rd, 0);
        check("wr_latency", lat, 2);
        do_cmd(1'b0, 16'h1004, 32'h0, rd, er);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_err", er, 0);
        check("rd_latency", lat, 2);

        mem[16'h1008] = 32'h0000_0055;
        slave_wait = 3;
        do_cmd(1'b0, 16'h1008, 32'h0, rd, er);
        check("wait_data", rd, 32'h55);
        check("wait_latency", lat, 5);
        check("wait_penable_cycles", pen_cnt, 4);
        slave_wait = 0;

        stall = 1'b1;
        do_cmd(1'b1, 16'h1010, 32'h7777_7777, rd, er);
        check("to_err", er, 1);
        check("to_rdata", rd, 0);
        check("to_latency", lat, 17);
        check("to_access_cycles", pen_cnt, 16);
        check("to_cmd_ready", cmd_ready, 1);
        check("to_psel", PSELx, 0);
        stall = 1'b0;

        slave_wait = 15;
        do_cmd(1'b0, 16'h1004, 32'h0, rd, er);
        check("edge_err", er, 0);
        check("edge_data", rd, 32'hDEAD_BEEF);
        check("edge_latency", lat, 17);

        slave_wait = 10;
        r0 = rsp_cnt;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h1008;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        check("mid_rst_psel", PSELx, 0);
        check("mid_rst_penable", PENABLE, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rdata", rsp_rdata, 0);
        check("mid_rst_paddr", PADDR, 0);
        repeat (20) @(posedge PCLK);
        #1 check("mid_rst_no_rsp", rsp_cnt - r0, 0);
        slave_wait = 0;
        do_cmd(1'b0, 16'h1004, 32'h0, rd, er);
        check("post_rst_data", rd, 32'hDEAD_BEEF);
        check("post_rst_latency", lat, 2);

        acc_edges.delete();
        r0 = rsp_cnt;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_write = 1'b1; cmd_addr = AW'(16'h1000 + 4 * i); cmd_wdata = vals[i];
            got = 1'b0;
            for (int j = 0; j < 20; j++) begin
                @(negedge PCLK);
                if (cmd_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check("b2b_accept", got, 1);
            @(posedge PCLK); #1;
        end
        cmd_valid = 1'b0;
        for (int j = 0; j < 20 && (rsp_cnt - r0) < 4; j++) @(negedge PCLK);
        repeat (3) @(posedge PCLK);
        #1;
        check("b2b_rsp_count", rsp_cnt - r0, 4);
        check("b2b_accept_count", acc_edges.size(), 4);
        for (int i = 1; i < acc_edges.size(); i++)
            check("b2b_spacing", acc_edges[i] - acc_edges[i-1], 3);
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, AW'(16'h1000 + 4 * i), 32'h0, rd, er);
            check("b2b_readback", rd, vals[i]);
        end

        @(posedge PCLK); #1;
        cmd_valid0 = 1'b1;
        @(posedge PCLK); #1;
        cmd_valid0 = 1'b0;
        @(posedge PCLK);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PCLK);
            if (!(psel0 && penable0 && !rsp_valid0 && !cmd_ready0)) bad++;
        end
        check("nowd_stuck_in_access", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500us");
        $fatal(1, "simulation time limit");
    end

endmodule
